uart_tx_engine: RTL

Parametrised UART transmit engine combining frame sequencing, serialisation, parity generation and line driving in one block, with data width and stop-bit count configurable. Sits between the transmit data source (FIFO or register interface) and the TX pin. Advances one bit per baud tick and supports back-to-back frames with no idle gap.

---
 rtl/uart_tx_engine.sv | 99 +++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter (start, DATA_WIDTH bits LSB first, optional parity, 1/2 stop bits), one bit per tick; ports clk, reset (async high), tick, p_data, data_valid, par_en, par_typ, stop2 -> tx_out, busy, data_ack; parity present only when UART_TX_PARITY_EN is defined
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  data_ack
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
  logic [2:0] state, state_nxt, after_data;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic stop_cnt, stop_cnt_nxt, stop2_q, last_stop, capture, tx_nxt;
  logic [DATA_WIDTH-1:0] data_q;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  logic par_en_q, par_typ_q;
  assign after_data = par_en_q ? PARITY : STOP;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (capture) begin
      par_en_q <= par_en;
      par_typ_q <= par_typ;
    end
`else
  logic unused_par;
  assign unused_par = par_en ^ par_typ;
  assign after_data = STOP;
`endif
  assign last_stop = stop_cnt == stop2_q;
  assign capture = tick && data_valid && (state == IDLE || (state == STOP && last_stop));
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    bit_cnt_nxt = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    case (state)
      IDLE: state_nxt = IDLE;
      START: if (tick) begin
        state_nxt = DATA;
        bit_cnt_nxt = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt == LAST) begin
          state_nxt = after_data;
          stop_cnt_nxt = 1'b0;
        end else bit_cnt_nxt = bit_cnt + 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_nxt = STOP;
        stop_cnt_nxt = 1'b0;
      end
`endif
      STOP: if (tick) begin
        if (last_stop) state_nxt = IDLE;
        else stop_cnt_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (capture) state_nxt = START;
    // Line level is derived from the next state so tx_out moves on the same edge as the state.
    tx_nxt = state_nxt == START ? 1'b0 : state_nxt == DATA ? data_q[bit_cnt_nxt] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state_nxt == PARITY) tx_nxt = ^data_q ^ par_typ_q;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      data_q <= '0;
      stop2_q <= 1'b0;
      tx_out <= 1'b1;
      data_ack <= 1'b0;
    end else begin
      state <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx_out <= tx_nxt;
      data_ack <= capture;
      if (capture) begin
        data_q <= p_data;
        stop2_q <= stop2;
      end
    end
endmodule
